// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store responder split into two 16-bit async SRAM accesses.
// Optional macro SRAM_ADDR_OFFSET_EN rebases byte address 1024 to SRAM half-word 0.
module sram_controller #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_r_m,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   eff;
    logic [16:0]   word;
    logic          cnt_last;
    logic          dq_oe;
    logic [15:0]   dq_out;
    logic          unused_eff_bits;

`ifdef SRAM_ADDR_OFFSET_EN
    assign eff = alu_res - 32'd1024;
`else
    assign eff = alu_res;
`endif

    // Byte lane bits and anything above the 256K half-word space are dropped.
    assign word            = eff[18:2];
    assign unused_eff_bits = ^{eff[31:19], eff[1:0]};
    assign cnt_last        = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        ready     = 1'b0;
        sram_we_n = 1'b1;
        sram_addr = {word, 1'b0};
        dq_oe     = 1'b0;
        dq_out    = val_r_m[15:0];

        case (state_q)
            S_IDLE: begin
                ready = !(mem_r_en || mem_w_en);
                if (mem_r_en || mem_w_en) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    wr_d    = mem_w_en;
                end
            end
            S_LOW: begin
                sram_we_n = !wr_q;
                dq_oe     = wr_q;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_dq;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                sram_addr = {word, 1'b1};
                sram_we_n = !wr_q;
                dq_oe     = wr_q;
                dq_out    = val_r_m[31:16];
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_dq;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                // Always return to IDLE so a request held through DONE is re-evaluated there.
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_dq = dq_oe ? dq_out : 16'bz;
    assign rdata   = rdata_q;

endmodule
